rotate_step_sequencer: RTL and testbench



---
 rtl/rotate_step_sequencer.sv | 104 ++++++++++
 tb/tb_rotate_step_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rotate_step_sequencer.sv
// Multi-pass front-end for a narrow combinational rotator: splits a rotation
// amount into steps of at most 2^STEP_W-1 and feeds each pass result back in.
//
// state  | meaning
// IDLE   | waiting for a request, o_ready high
// ROTATE | one rotator pass per clock until the remaining amount reaches zero
// DONE   | result held on o_data/o_steps until downstream takes it
module rotate_step_sequencer #(
   parameter int WIDTH  = 16,
   parameter int STEP_W = 2,
   parameter int AMT_W  = 8
) (
   input  logic              i_clk,
   input  logic              i_RESET,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [WIDTH-1:0]  i_data,
   input  logic [AMT_W-1:0]  i_amount,
   input  logic              i_dir,
   output logic [WIDTH-1:0]  o_rot_in,
   output logic [STEP_W-1:0] o_shamt,
   input  logic [WIDTH-1:0]  i_rot_right,
   input  logic [WIDTH-1:0]  i_rot_left,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [WIDTH-1:0]  o_data,
   output logic [AMT_W-1:0]  o_steps
);
   localparam int LOG_W    = $clog2(WIDTH);
   localparam int MAX_STEP = (1 << STEP_W) - 1;

   typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] work, work_nxt;
   logic [LOG_W-1:0] remaining, remaining_nxt;
   logic [LOG_W-1:0] eff, step;
   logic             dir, dir_nxt;
   logic [AMT_W-1:0] steps, steps_nxt;

   // Amounts that are multiples of WIDTH collapse to zero here
   assign eff = i_amount[LOG_W-1:0];

   always_comb begin
      if (int'(remaining) > MAX_STEP) step = LOG_W'(MAX_STEP);
      else                            step = remaining;
   end

   always_ff @(posedge i_clk or posedge i_RESET) begin
      if (i_RESET) begin
         state     <= IDLE;
         work      <= '0;
         remaining <= '0;
         dir       <= 1'b0;
         steps     <= '0;
      end else begin
         state     <= state_nxt;
         work      <= work_nxt;
         remaining <= remaining_nxt;
         dir       <= dir_nxt;
         steps     <= steps_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      work_nxt      = work;
      remaining_nxt = remaining;
      dir_nxt       = dir;
      steps_nxt     = steps;
      o_ready       = 1'b0;
      o_valid       = 1'b0;
      o_shamt       = '0;
      case (state)
         IDLE: begin
            o_ready = ~i_RESET;
            if (i_valid) begin
               work_nxt      = i_data;
               dir_nxt       = i_dir;
               remaining_nxt = eff;
               steps_nxt     = '0;
               state_nxt     = (eff == '0) ? DONE : ROTATE;
            end
         end
         ROTATE: begin
            o_shamt       = STEP_W'(step);
            work_nxt      = dir ? i_rot_left : i_rot_right;
            remaining_nxt = remaining - step;
            steps_nxt     = steps + AMT_W'(1);
            if (remaining == step) state_nxt = DONE;
         end
         DONE: begin
            o_valid = 1'b1;
            if (i_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign o_rot_in = work;
   assign o_data   = work;
   assign o_steps  = steps;

endmodule

// File: tb/tb_rotate_step_sequencer.sv
// Bench for rotate_step_sequencer: external rotator modelled inline, a
// whole-request reference model checked every cycle, plus directed cases.
module tb_rotate_step_sequencer;
   localparam int WIDTH    = 16;
   localparam int STEP_W   = 2;
   localparam int AMT_W    = 8;
   localparam int MAX_STEP = 3;

   logic              i_clk    = 1'b0;
   logic              i_RESET  = 1'b0;
   logic              i_valid  = 1'b0;
   logic              i_dir    = 1'b0;
   logic              i_ready  = 1'b0;
   logic [WIDTH-1:0]  i_data   = '0;
   logic [AMT_W-1:0]  i_amount = '0;
   logic              o_ready, o_valid;
   logic [WIDTH-1:0]  o_rot_in, o_data, i_rot_right, i_rot_left;
   logic [STEP_W-1:0] o_shamt;
   logic [AMT_W-1:0]  o_steps;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   always #5 i_clk = ~i_clk;

   function automatic logic [15:0] rotr(input logic [15:0] x, input int n);
      logic [31:0] d;
      d = {x, x} >> (n % 16);
      return d[15:0];
   endfunction

   function automatic logic [15:0] rotl(input logic [15:0] x, input int n);
      return rotr(x, (16 - (n % 16)) % 16);
   endfunction

   function automatic logic [15:0] rot(input logic [15:0] x, input int n, input logic dl);
      return dl ? rotl(x, n) : rotr(x, n);
   endfunction

   assign i_rot_right = rotr(o_rot_in, int'(o_shamt));
   assign i_rot_left  = rotl(o_rot_in, int'(o_shamt));

   rotate_step_sequencer #(.WIDTH(WIDTH), .STEP_W(STEP_W), .AMT_W(AMT_W)) dut (
      .i_clk(i_clk), .i_RESET(i_RESET), .i_valid(i_valid), .o_ready(o_ready),
      .i_data(i_data), .i_amount(i_amount), .i_dir(i_dir),
      .o_rot_in(o_rot_in), .o_shamt(o_shamt),
      .i_rot_right(i_rot_right), .i_rot_left(i_rot_left),
      .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_steps(o_steps)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Request-level model: a request is busy for ceil(eff/MAX_STEP) passes, then valid
   bit          m_busy = 1'b0, m_valid = 1'b0;
   int          m_eff = 0, m_npass = 0, m_pass = 0;
   logic [15:0] m_src = '0, m_exp = '0;
   logic        m_dir = 1'b0;

   always @(posedge i_clk or posedge i_RESET) begin
      if (i_RESET) begin
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
      end else if (m_valid) begin
         if (i_ready) m_valid <= 1'b0;
      end else if (m_busy) begin
         m_pass <= m_pass + 1;
         if (m_pass + 1 == m_npass) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b1;
         end
      end else if (i_valid) begin
         m_src   <= i_data;
         m_dir   <= i_dir;
         m_eff   <= int'(i_amount) % WIDTH;
         m_npass <= (int'(i_amount) % WIDTH + MAX_STEP - 1) / MAX_STEP;
         m_pass  <= 0;
         m_exp   <= rot(i_data, int'(i_amount) % WIDTH, i_dir);
         if (int'(i_amount) % WIDTH == 0) m_valid <= 1'b1;
         else                             m_busy  <= 1'b1;
      end
   end

   always @(negedge i_clk) begin
      if (cmp_en) begin
         if (i_RESET) begin
            chk("rst_ready", o_ready, 0);
            chk("rst_valid", o_valid, 0);
            chk("rst_shamt", o_shamt, 0);
            chk("rst_rot_in", o_rot_in, 0);
            chk("rst_data", o_data, 0);
            chk("rst_steps", o_steps, 0);
         end else begin
            chk("m_ready", o_ready, (!m_busy && !m_valid) ? 1 : 0);
            chk("m_valid", o_valid, m_valid ? 1 : 0);
            chk("m_shamt", o_shamt,
                m_busy ? ((m_eff - MAX_STEP * m_pass) < MAX_STEP ? m_eff - MAX_STEP * m_pass : MAX_STEP) : 0);
            if (m_busy) chk("m_rot_in", o_rot_in, rot(m_src, MAX_STEP * m_pass, m_dir));
            if (m_valid) begin
               chk("m_data", o_data, m_exp);
               chk("m_steps", o_steps, m_npass);
            end
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!o_ready && n < 20) begin
         @(posedge i_clk); #1;
         n++;
      end
      chk("req_ready", o_ready, 1);
   endtask

   task automatic req(input logic [15:0] d, input logic [7:0] a, input logic dr, input int hold,
                      input logic [15:0] exp_d, input int exp_steps, input int exp_lat, input int exp_sh);
      int lat;
      wait_ready();
      i_valid = 1'b1; i_data = d; i_amount = a; i_dir = dr; i_ready = 1'b0;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      chk("first_shamt", o_shamt, exp_sh);
      lat = 1;
      while (!o_valid && lat < 20) begin
         @(posedge i_clk); #1;
         lat++;
      end
      chk("latency", lat, exp_lat);
      chk("data", o_data, exp_d);
      chk("steps", o_steps, exp_steps);
      for (int k = 0; k < hold; k++) begin
         i_valid = 1'b1; i_data = ~d; i_amount = 8'd3;
         @(posedge i_clk); #1;
         chk("bp_valid", o_valid, 1);
         chk("bp_data", o_data, exp_d);
         chk("bp_steps", o_steps, exp_steps);
         chk("bp_ready", o_ready, 0);
      end
      i_valid = 1'b0; i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
      chk("post_valid", o_valid, 0);
      chk("post_ready", o_ready, 1);
   endtask

   initial begin
      int done_cnt;
      done_cnt = 0;
      #1 i_RESET = 1'b1;
      #1 cmp_en = 1'b1;
      repeat (3) @(posedge i_clk);
      #1 i_RESET = 1'b0;
      #1;
      chk("reset_ready", o_ready, 1);
      chk("reset_valid", o_valid, 0);
      chk("reset_data", o_data, 0);
      chk("reset_steps", o_steps, 0);

      req(16'h0007, 8'd5,    1'b0, 0, 16'h3800, 2, 3, 3);
      req(16'h8001, 8'h13,   1'b1, 0, 16'h000C, 1, 2, 3);
      req(16'hA5C3, 8'd16,   1'b0, 0, 16'hA5C3, 0, 1, 0);
      req(16'h0001, 8'd15,   1'b1, 0, 16'h8000, 5, 6, 3);
      req(16'h1234, 8'd7,    1'b0, 4, 16'h6824, 3, 4, 3);

      // Asynchronous reset two cycles into a long rotation
      wait_ready();
      i_valid = 1'b1; i_data = 16'h0001; i_amount = 8'd15; i_dir = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      @(posedge i_clk);
      @(posedge i_clk); #1;
      chk("pre_rst_shamt", o_shamt, 3);
      i_RESET = 1'b1;
      #1;
      chk("arst_ready", o_ready, 0);
      chk("arst_valid", o_valid, 0);
      chk("arst_shamt", o_shamt, 0);
      chk("arst_rot_in", o_rot_in, 0);
      chk("arst_data", o_data, 0);
      chk("arst_steps", o_steps, 0);
      @(posedge i_clk); #1;
      i_RESET = 1'b0;
      #1;
      chk("rel_ready", o_ready, 1);
      req(16'h0007, 8'd5, 1'b0, 0, 16'h3800, 2, 3, 3);

      for (int c = 0; c < 3000; c++) begin
         i_valid  = ($urandom_range(0, 1) == 1);
         i_data   = 16'($urandom);
         i_amount = ($urandom_range(0, 7) == 0) ? 8'(16 * $urandom_range(0, 15))
                                                : 8'($urandom_range(0, 255));
         i_dir    = 1'($urandom_range(0, 1));
         i_ready  = ($urandom_range(0, 3) != 0);
         @(negedge i_clk);
         if (o_valid && i_ready) done_cnt++;
         @(posedge i_clk); #1;
      end
      chk("rand_progress", (done_cnt > 100) ? 1 : 0, 1);

      i_valid = 1'b0; i_ready = 1'b1;
      repeat (10) @(posedge i_clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
